// File: rtl/fmdll_lock_ctrl_if.sv
// Control/status bundle between the FMDLL lock controller and its surroundings.
// Signal suffixes are relative to the controller (slave): _i driven in, _o driven out.
interface fmdll_lock_ctrl_if #(
  parameter int CODE_W = 6
);
  logic              en_i;
  logic              sel_fine_i;
  logic [1:0]        m_i;
  logic [1:0]        m_counter_i;
  logic              n_wrap_tgl_i;
  logic [CODE_W-1:0] dco_code_o;
  logic              update_o;
  logic              locked_o;
  logic [1:0]        state_o;

  modport master (
    output en_i, sel_fine_i, m_i, m_counter_i, n_wrap_tgl_i,
    input  dco_code_o, update_o, locked_o, state_o
  );

  modport slave (
    input  en_i, sel_fine_i, m_i, m_counter_i, n_wrap_tgl_i,
    output dco_code_o, update_o, locked_o, state_o
  );
endinterface

// File: rtl/fmdll_lock_ctrl.sv
// FMDLL frequency-lock controller: counts clk_out wrap events per reference window
// and steers the DCO code coarse, then fine, until lock.
module fmdll_lock_ctrl #(
  parameter int CODE_W      = 6,
  parameter int CODE_INIT   = 32,
  parameter int STEP_COARSE = 4,
  parameter int LOCK_CNT    = 4,
  parameter int UNLOCK_CNT  = 2
) (
  input  logic             clk_ext,
  input  logic             rst_n,
  fmdll_lock_ctrl_if.slave bus
);

  // state    | meaning
  // IDLE     | disabled, or discarding the first partial window after enable
  // COARSE   | large steps until match or step-direction reversal
  // FINE     | unit steps, counting consecutive matching windows
  // LOCKED   | lock asserted, unit trimming, counting consecutive misses
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_COARSE = 2'd1;
  localparam logic [1:0] ST_FINE   = 2'd2;
  localparam logic [1:0] ST_LOCKED = 2'd3;

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int UW = $clog2(UNLOCK_CNT + 1);

  localparam logic [CODE_W-1:0] CODE_RST = CODE_W'(CODE_INIT);
  localparam logic [CODE_W-1:0] CODE_MAX = '1;
  localparam logic [CODE_W-1:0] STEP_C   = CODE_W'(STEP_COARSE);
  localparam logic [CODE_W-1:0] ONE_C    = CODE_W'(1);
  localparam logic [MW-1:0]     MATCH_LAST = MW'(LOCK_CNT - 1);
  localparam logic [UW-1:0]     MISS_LAST  = UW'(UNLOCK_CNT - 1);

  logic [2:0]        tgl_q, tgl_d;
  logic [2:0]        win_cnt_q, win_cnt_d;
  logic [1:0]        state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              upd_q, upd_d;
  logic              locked_q, locked_d;
  logic              en_q;
  logic              skip_q, skip_d;
  logic [MW-1:0]     match_q, match_d;
  logic [UW-1:0]     miss_q, miss_d;
  logic              dir_vld_q, dir_vld_d;
  logic              dir_up_q, dir_up_d;

  logic              n_evt, wb, en_rise;
  logic [2:0]        eval;
  logic              slow, match;
  logic [CODE_W-1:0] code_cup, code_cdn, code_fup, code_fdn;

  // tgl_q[1] is the synchronized toggle; tgl_q[2] is its one-cycle-old copy
  assign tgl_d   = {tgl_q[1:0], bus.n_wrap_tgl_i};
  assign n_evt   = tgl_q[1] ^ tgl_q[2];
  assign wb      = (bus.m_counter_i == bus.m_i);
  assign en_rise = bus.en_i & ~en_q;

  // An event arriving on the boundary cycle belongs to the window it closes
  assign eval      = (win_cnt_q == 3'd7) ? 3'd7 : win_cnt_q + {2'b00, n_evt};
  assign win_cnt_d = wb ? 3'd0 : eval;
  assign slow      = (eval == 3'd0);
  assign match     = (eval == 3'd1);

  assign code_cup = (code_q > CODE_MAX - STEP_C) ? CODE_MAX : code_q + STEP_C;
  assign code_cdn = (code_q < STEP_C) ? '0 : code_q - STEP_C;
  assign code_fup = (code_q == CODE_MAX) ? CODE_MAX : code_q + ONE_C;
  assign code_fdn = (code_q == '0) ? '0 : code_q - ONE_C;

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    locked_d  = locked_q;
    skip_d    = skip_q;
    match_d   = match_q;
    miss_d    = miss_q;
    dir_vld_d = dir_vld_q;
    dir_up_d  = dir_up_q;
    upd_d     = 1'b0;

    if (!bus.en_i) begin
      state_d  = ST_IDLE;
      locked_d = 1'b0;
      skip_d   = 1'b0;
    end else if (en_rise) begin
      state_d  = ST_IDLE;
      code_d   = CODE_RST;
      locked_d = 1'b0;
      skip_d   = 1'b1;
    end else if (wb) begin
      case (state_q)
        ST_IDLE: begin
          if (skip_q) begin
            skip_d    = 1'b0;
            state_d   = bus.sel_fine_i ? ST_FINE : ST_COARSE;
            dir_vld_d = 1'b0;
            match_d   = '0;
            miss_d    = '0;
          end
        end
        ST_COARSE: begin
          // A direction reversal means the target lies within one coarse step
          if (match || (dir_vld_q && (dir_up_q != slow))) begin
            state_d = ST_FINE;
            match_d = '0;
          end else begin
            code_d    = slow ? code_cup : code_cdn;
            dir_vld_d = 1'b1;
            dir_up_d  = slow;
          end
        end
        ST_FINE: begin
          if (match) begin
            if (match_q == MATCH_LAST) begin
              state_d  = ST_LOCKED;
              locked_d = 1'b1;
              miss_d   = '0;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            match_d = '0;
            code_d  = slow ? code_fup : code_fdn;
          end
        end
        default: begin
          if (match) begin
            miss_d = '0;
          end else begin
            code_d = slow ? code_fup : code_fdn;
            if (miss_q == MISS_LAST) begin
              state_d  = ST_FINE;
              locked_d = 1'b0;
              match_d  = '0;
              miss_d   = '0;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end
        end
      endcase
      upd_d = (code_d != code_q);
    end
  end

  always_ff @(posedge clk_ext or negedge rst_n) begin
    if (!rst_n) begin
      tgl_q     <= '0;
      win_cnt_q <= '0;
      state_q   <= ST_IDLE;
      code_q    <= CODE_RST;
      upd_q     <= 1'b0;
      locked_q  <= 1'b0;
      en_q      <= 1'b0;
      skip_q    <= 1'b0;
      match_q   <= '0;
      miss_q    <= '0;
      dir_vld_q <= 1'b0;
      dir_up_q  <= 1'b0;
    end else begin
      tgl_q     <= tgl_d;
      win_cnt_q <= win_cnt_d;
      state_q   <= state_d;
      code_q    <= code_d;
      upd_q     <= upd_d;
      locked_q  <= locked_d;
      en_q      <= bus.en_i;
      skip_q    <= skip_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      dir_vld_q <= dir_vld_d;
      dir_up_q  <= dir_up_d;
    end
  end

  assign bus.dco_code_o = code_q;
  assign bus.update_o   = upd_q;
  assign bus.locked_o   = locked_q;
  assign bus.state_o    = state_q;

endmodule

// File: tb/tb_fmdll_lock_ctrl.sv
// Directed bench for fmdll_lock_ctrl: one DUT at the default initial code, a second
// at initial code 62 for the saturation corner; both share the same stimulus.
module tb_fmdll_lock_ctrl;

  logic clk_ext = 1'b0;
  always #5 clk_ext = ~clk_ext;

  logic       rst_n;
  logic       en, sel, tog;
  logic [1:0] mval, mc;

  fmdll_lock_ctrl_if #(.CODE_W(6)) bus0 ();
  fmdll_lock_ctrl_if #(.CODE_W(6)) bus1 ();

  assign bus0.en_i = en;
  assign bus0.sel_fine_i = sel;
  assign bus0.m_i = mval;
  assign bus0.m_counter_i = mc;
  assign bus0.n_wrap_tgl_i = tog;
  assign bus1.en_i = en;
  assign bus1.sel_fine_i = sel;
  assign bus1.m_i = mval;
  assign bus1.m_counter_i = mc;
  assign bus1.n_wrap_tgl_i = tog;

  fmdll_lock_ctrl #(.CODE_W(6), .CODE_INIT(32)) dut0 (.clk_ext(clk_ext), .rst_n(rst_n), .bus(bus0));
  fmdll_lock_ctrl #(.CODE_W(6), .CODE_INIT(62)) dut1 (.clk_ext(clk_ext), .rst_n(rst_n), .bus(bus1));

  typedef struct {
    int         ntog;
    bit         en;
    bit         sel;
    logic [5:0] code;
    logic [1:0] st;
    bit         upd;
    bit         lck;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad = 0;
  logic upd0, upd1;
  int   stray0, stray1;

  function automatic vec_t mk(int nt, int e, int s, int code, int st, int u, int l);
    vec_t v;
    v.ntog = nt;
    v.en   = (e != 0);
    v.sel  = (s != 0);
    v.code = 6'(code);
    v.st   = 2'(st);
    v.upd  = (u != 0);
    v.lck  = (l != 0);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // One reference window with M=3: counter 0..3, boundary on the last cycle.
  // Toggles on the first two cycles land inside this window (the second one on the boundary).
  task automatic do_window(input int ntog, input bit en_v, input bit sel_v);
    stray0 = 0;
    stray1 = 0;
    for (int c = 0; c < 4; c++) begin
      mc = 2'(c);
      if (c == 0) begin
        en  = en_v;
        sel = sel_v;
      end
      if ((c == 0 && ntog >= 1) || (c == 1 && ntog >= 2)) tog = ~tog;
      @(posedge clk_ext);
      #1;
      if (c == 3) begin
        upd0 = bus0.update_o;
        upd1 = bus1.update_o;
      end else begin
        if (bus0.update_o) stray0++;
        if (bus1.update_o) stray1++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    sel = 1'b0;
    tog = 1'b0;
    mval = 2'd3;
    mc = 2'd0;

    // idle, coarse up, coarse->fine->lock, locked trim/unlock, re-enable, fast/reversal
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 0, 32, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 32, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 36, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 40, 1, 1, 0));
    vecs.push_back(mk(1, 1, 0, 40, 2, 0, 0));
    vecs.push_back(mk(1, 1, 0, 40, 2, 0, 0));
    vecs.push_back(mk(1, 1, 0, 40, 2, 0, 0));
    vecs.push_back(mk(1, 1, 0, 40, 2, 0, 0));
    vecs.push_back(mk(1, 1, 0, 40, 3, 0, 1));
    vecs.push_back(mk(0, 1, 0, 41, 3, 1, 1));
    vecs.push_back(mk(1, 1, 0, 41, 3, 0, 1));
    vecs.push_back(mk(0, 1, 0, 42, 3, 1, 1));
    vecs.push_back(mk(0, 1, 0, 43, 2, 1, 0));
    vecs.push_back(mk(2, 1, 0, 42, 2, 1, 0));
    vecs.push_back(mk(0, 0, 0, 42, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 32, 2, 0, 0));
    vecs.push_back(mk(0, 1, 1, 33, 2, 1, 0));
    vecs.push_back(mk(2, 1, 1, 32, 2, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32, 0, 0, 0));
    vecs.push_back(mk(2, 1, 0, 32, 1, 0, 0));
    vecs.push_back(mk(2, 1, 0, 28, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 28, 2, 0, 0));
    vecs.push_back(mk(2, 1, 0, 27, 2, 1, 0));

    repeat (3) @(posedge clk_ext);
    #1;
    chk("rst_code0", 32'(bus0.dco_code_o), 32);
    chk("rst_code1", 32'(bus1.dco_code_o), 62);
    chk("rst_state", 32'(bus0.state_o), 0);
    chk("rst_locked", 32'(bus0.locked_o), 0);
    chk("rst_update", 32'(bus0.update_o), 0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      do_window(vecs[i].ntog, vecs[i].en, vecs[i].sel);
      chk($sformatf("v%0d_code", i), 32'(bus0.dco_code_o), 32'(vecs[i].code));
      chk($sformatf("v%0d_state", i), 32'(bus0.state_o), 32'(vecs[i].st));
      chk($sformatf("v%0d_update", i), 32'(upd0), 32'(vecs[i].upd));
      chk($sformatf("v%0d_locked", i), 32'(bus0.locked_o), 32'(vecs[i].lck));
      chk($sformatf("v%0d_stray_upd", i), 32'(stray0), 0);
    end

    // saturation at the top code on the 62-init instance, fine mode
    do_window(0, 1'b0, 1'b0);
    chk("sat_idle_state", 32'(bus1.state_o), 0);
    do_window(0, 1'b1, 1'b1);
    chk("sat_init_code", 32'(bus1.dco_code_o), 62);
    chk("sat_init_state", 32'(bus1.state_o), 2);
    do_window(0, 1'b1, 1'b1);
    chk("sat_step_code", 32'(bus1.dco_code_o), 63);
    chk("sat_step_upd", 32'(upd1), 1);
    for (int k = 0; k < 2; k++) begin
      do_window(0, 1'b1, 1'b1);
      chk($sformatf("sat_hold%0d_code", k), 32'(bus1.dco_code_o), 63);
      chk($sformatf("sat_hold%0d_upd", k), 32'(upd1), 0);
      chk($sformatf("sat_hold%0d_stray", k), 32'(stray1), 0);
    end
    chk("sat_dut0_code", 32'(bus0.dco_code_o), 35);

    // drive both instances into lock, then hit reset mid-window
    for (int k = 0; k < 4; k++) do_window(1, 1'b1, 1'b1);
    chk("pre_rst_locked0", 32'(bus0.locked_o), 1);
    chk("pre_rst_locked1", 32'(bus1.locked_o), 1);
    chk("pre_rst_code0", 32'(bus0.dco_code_o), 35);
    mc = 2'd0;
    @(posedge clk_ext);
    #1;
    mc = 2'd1;
    @(posedge clk_ext);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_code0", 32'(bus0.dco_code_o), 32);
    chk("arst_code1", 32'(bus1.dco_code_o), 62);
    chk("arst_state0", 32'(bus0.state_o), 0);
    chk("arst_locked0", 32'(bus0.locked_o), 0);
    chk("arst_locked1", 32'(bus1.locked_o), 0);
    chk("arst_update0", 32'(bus0.update_o), 0);
    repeat (2) @(posedge clk_ext);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk_ext);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
